// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: state encoding (as seen on state_o)
// and the timer sizing helper.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      ST_PLL_RESET   = 2'd0,
      ST_WAIT_LOCK   = 2'd1,
      ST_STABLE_WAIT = 2'd2,
      ST_RUN         = 2'd3
   } sup_state_e;

   // One shared timer covers all three timed states, so size it for the longest.
   function automatic int timer_width(input int rst_cycles, input int timeout_cycles,
                                      input int stable_cycles);
      int max_v;
      max_v = rst_cycles;
      if (timeout_cycles > max_v) max_v = timeout_cycles;
      if (stable_cycles > max_v) max_v = stable_cycles;
      return $clog2(max_v + 1);
   endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module bit_sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, waits for a debounced lock, then releases the serial-clock
// reset; re-resets the PLL on lock timeout or filtered lock loss, and counts both events.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 250000,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOSS_FILTER_CYCLES  = 4,
   parameter int CNT_W               = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pll_locked_i,
   input  logic             clr_count_i,
   output logic             pll_rst_o,
   output logic             sys_rst_o,
   output logic             ready_o,
   output logic [CNT_W-1:0] loss_count_o,
   output logic [CNT_W-1:0] retry_count_o,
   output logic [1:0]       state_o
);

   localparam int TMR_W = timer_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
   localparam int FLT_W = $clog2(LOSS_FILTER_CYCLES + 1);

   localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [FLT_W-1:0] FILTER_LAST  = FLT_W'(LOSS_FILTER_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   logic lk;

   sup_state_e       state_q,   state_d;
   logic [TMR_W-1:0] timer_q,   timer_d;
   logic [FLT_W-1:0] filter_q,  filter_d;
   logic [CNT_W-1:0] loss_q,    loss_d;
   logic [CNT_W-1:0] retry_q,   retry_d;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_rst_q, sys_rst_d;
   logic             ready_q,   ready_d;
   logic             loss_inc;
   logic             retry_inc;

   bit_sync_2ff u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d_i (pll_locked_i),
      .q_o (lk)
   );

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      filter_d  = '0;
      loss_inc  = 1'b0;
      retry_inc = 1'b0;

      case (state_q)
         ST_PLL_RESET: begin
            if (timer_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         // Lock is checked before the timeout so a lock on the last cycle still wins.
         ST_WAIT_LOCK: begin
            if (lk) begin
               state_d = ST_STABLE_WAIT;
               timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
               state_d   = ST_PLL_RESET;
               timer_d   = '0;
               retry_inc = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_STABLE_WAIT: begin
            if (!lk) begin
               state_d = ST_WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STABLE_LAST) begin
               state_d = ST_RUN;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_RUN: begin
            // filter_q holds the unlocked cycles already seen; this one completes the run.
            if (!lk) begin
               if (filter_q == FILTER_LAST) begin
                  state_d  = ST_PLL_RESET;
                  timer_d  = '0;
                  loss_inc = 1'b1;
               end else begin
                  filter_d = filter_q + 1'b1;
               end
            end
         end
      endcase

      loss_d  = loss_q;
      retry_d = retry_q;
      if (clr_count_i) begin
         loss_d  = '0;
         retry_d = '0;
      end else begin
         if (loss_inc && (loss_q != CNT_MAX)) loss_d = loss_q + 1'b1;
         if (retry_inc && (retry_q != CNT_MAX)) retry_d = retry_q + 1'b1;
      end

      pll_rst_d = (state_d == ST_PLL_RESET);
      sys_rst_d = (state_d != ST_RUN);
      ready_d   = (state_d == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_PLL_RESET;
         timer_q   <= '0;
         filter_q  <= '0;
         loss_q    <= '0;
         retry_q   <= '0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         filter_q  <= filter_d;
         loss_q    <= loss_d;
         retry_q   <= retry_d;
         pll_rst_q <= pll_rst_d;
         sys_rst_q <= sys_rst_d;
         ready_q   <= ready_d;
      end
   end

   assign pll_rst_o     = pll_rst_q;
   assign sys_rst_o     = sys_rst_q;
   assign ready_o       = ready_q;
   assign loss_count_o  = loss_q;
   assign retry_count_o = retry_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus steps a behavioural model and queues expected outputs,
// a monitor pops and compares after every clock edge.
module tb_pll_lock_supervisor;

   localparam int P_RST   = 4;
   localparam int P_TO    = 100;
   localparam int P_STB   = 8;
   localparam int P_LOSS  = 3;
   localparam int P_CNTW  = 8;
   localparam int CNT_SAT = 255;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pll_locked_i = 1'b0;
   logic              clr_count_i = 1'b0;
   logic              pll_rst_o;
   logic              sys_rst_o;
   logic              ready_o;
   logic [P_CNTW-1:0] loss_count_o;
   logic [P_CNTW-1:0] retry_count_o;
   logic [1:0]        state_o;

   int vectors = 0;
   int miscompares = 0;

   pll_lock_supervisor #(
      .PLL_RST_CYCLES      (P_RST),
      .LOCK_TIMEOUT_CYCLES (P_TO),
      .LOCK_STABLE_CYCLES  (P_STB),
      .LOSS_FILTER_CYCLES  (P_LOSS),
      .CNT_W               (P_CNTW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pll_locked_i  (pll_locked_i),
      .clr_count_i   (clr_count_i),
      .pll_rst_o     (pll_rst_o),
      .sys_rst_o     (sys_rst_o),
      .ready_o       (ready_o),
      .loss_count_o  (loss_count_o),
      .retry_count_o (retry_count_o),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int prst;
      int srst;
      int rdy;
      int loss;
      int retry;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: mode names 0..3, time in mode measured from the entry edge.
   int m_mode, m_enter, m_cyc, m_zeros, m_loss, m_retry;
   bit in_hist[$];

   function automatic void model_reset();
      m_mode  = 0;
      m_enter = -1;
      m_cyc   = 0;
      m_zeros = 0;
      m_loss  = 0;
      m_retry = 0;
      in_hist.delete();
   endfunction

   // Synchronized lock seen at the coming edge is the input sampled two edges earlier.
   function automatic bit model_lk();
      return (in_hist.size() == 2) ? in_hist[0] : 1'b0;
   endfunction

   function automatic bit model_loss_now();
      return (m_mode == 3) && !model_lk() && (m_zeros + 1 == P_LOSS);
   endfunction

   function automatic void model_step(input bit lock_in, input bit clr);
      bit lk;
      int elapsed;
      int next_mode;
      bit loss_ev, retry_ev;
      exp_t e;
      lk        = model_lk();
      elapsed   = m_cyc - m_enter;
      next_mode = m_mode;
      loss_ev   = 1'b0;
      retry_ev  = 1'b0;
      case (m_mode)
         0: if (elapsed == P_RST) next_mode = 1;
         1: if (lk) next_mode = 2;
            else if (elapsed == P_TO) begin next_mode = 0; retry_ev = 1'b1; end
         2: if (!lk) next_mode = 1;
            else if (elapsed == P_STB) next_mode = 3;
         default: begin
            m_zeros = lk ? 0 : m_zeros + 1;
            if (m_zeros == P_LOSS) begin next_mode = 0; loss_ev = 1'b1; end
         end
      endcase
      if (next_mode != m_mode || loss_ev || retry_ev) begin
         m_enter = m_cyc;
         m_zeros = 0;
      end
      m_mode = next_mode;
      if (clr) begin
         m_loss  = 0;
         m_retry = 0;
      end else begin
         if (loss_ev && m_loss < CNT_SAT) m_loss++;
         if (retry_ev && m_retry < CNT_SAT) m_retry++;
      end
      in_hist.push_back(lock_in);
      if (in_hist.size() > 2) void'(in_hist.pop_front());
      m_cyc++;
      e.st    = m_mode;
      e.prst  = (m_mode == 0) ? 1 : 0;
      e.srst  = (m_mode == 3) ? 0 : 1;
      e.rdy   = (m_mode == 3) ? 1 : 0;
      e.loss  = m_loss;
      e.retry = m_retry;
      exp_q.push_back(e);
   endfunction

   // Called at a negedge: drive inputs for the next edge, queue its expected outputs.
   task automatic cyc(input bit lock_in, input bit clr);
      pll_locked_i = lock_in;
      clr_count_i  = clr;
      model_step(lock_in, clr);
      @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (int'(state_o) != e.st || int'(pll_rst_o) != e.prst || int'(sys_rst_o) != e.srst ||
             int'(ready_o) != e.rdy || int'(loss_count_o) != e.loss ||
             int'(retry_count_o) != e.retry) begin
            miscompares++;
            $display("FAIL edge_outputs t=%0t: got st=%0d prst=%0d srst=%0d rdy=%0d loss=%0d retry=%0d expected st=%0d prst=%0d srst=%0d rdy=%0d loss=%0d retry=%0d",
                     $time, state_o, pll_rst_o, sys_rst_o, ready_o, loss_count_o, retry_count_o,
                     e.st, e.prst, e.srst, e.rdy, e.loss, e.retry);
         end
      end
   end

   initial begin
      bit lock_v;
      bit clr_hit;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_pll_rst", int'(pll_rst_o), 1);
      check("reset_sys_rst", int'(sys_rst_o), 1);
      check("reset_ready", int'(ready_o), 0);
      check("reset_state", int'(state_o), 0);
      check("reset_loss", int'(loss_count_o), 0);
      check("reset_retry", int'(retry_count_o), 0);

      // Release reset; edge 0 is the next rising edge. Lock is sampled high from edge 10.
      rst = 1'b0;
      model_reset();
      repeat (10) cyc(1'b0, 1'b0);
      repeat (10) cyc(1'b1, 1'b0);
      check("stable_wait_before_edge20", int'(state_o), 2);
      check("not_ready_before_edge20", int'(ready_o), 0);
      cyc(1'b1, 1'b0);
      check("ready_at_edge20", int'(ready_o), 1);
      check("sys_rst_low_at_edge20", int'(sys_rst_o), 0);

      // Lock never returns: one loss, then repeated timeouts.
      repeat (330) cyc(1'b0, 1'b0);
      check("retry_after_timeouts", int'(retry_count_o), 3);
      check("loss_after_drop", int'(loss_count_o), 1);

      // Relock, then short glitches and a qualifying loss.
      repeat (20) cyc(1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0);
      repeat (6) cyc(1'b1, 1'b0);
      check("short_glitch_keeps_run", int'(ready_o), 1);
      repeat (3) cyc(1'b0, 1'b0);
      repeat (20) cyc(1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(1, 4)) cyc(1'b0, 1'b0);
         repeat ($urandom_range(2, 16)) cyc(1'b1, 1'b0);
      end

      // Randomized lock toggling with occasional counter clears.
      lock_v = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) lock_v = ~lock_v;
         cyc(lock_v, ($urandom_range(0, 49) == 0));
      end

      // Drive the loss counter into saturation.
      for (int i = 0; i < 260; i++) begin
         repeat (24) cyc(1'b1, 1'b0);
         repeat (5) cyc(1'b0, 1'b0);
      end
      check("loss_saturated", int'(loss_count_o), CNT_SAT);

      // Clear on the very edge a loss is counted.
      repeat (24) cyc(1'b1, 1'b0);
      clr_hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (model_loss_now()) begin
            clr_hit = 1'b1;
            cyc(1'b0, 1'b1);
         end else begin
            cyc(1'b0, 1'b0);
         end
      end
      check("clear_coincided_with_loss", int'(clr_hit), 1);
      check("clear_beats_increment", int'(loss_count_o), 0);

      // Asynchronous reset between edges while in RUN.
      repeat (24) cyc(1'b1, 1'b0);
      check("in_run_before_async_rst", int'(state_o), 3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pll_rst", int'(pll_rst_o), 1);
      check("async_rst_sys_rst", int'(sys_rst_o), 1);
      check("async_rst_ready", int'(ready_o), 0);
      check("async_rst_state", int'(state_o), 0);
      check("async_rst_retry", int'(retry_count_o), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 200; i++) cyc(($urandom_range(0, 3) != 0), 1'b0);

      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
